// File: rtl/aes_kb_pkg.sv
// Shared constants, state encoding and index helpers for the AES-128 round-key buffer.
package aes_kb_pkg;

  localparam int unsigned NR     = 10;
  localparam int unsigned NK     = NR + 1;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned RK_W   = 128;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CAPT  = 2'd1,
    SERVE = 2'd2
  } kb_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] w0;
    logic [WORD_W-1:0] w1;
    logic [WORD_W-1:0] w2;
    logic [WORD_W-1:0] w3;
  } rk_words_t;

  // First index served in a pass.
  function automatic logic [IDX_W-1:0] start_idx(input logic fwd);
    return fwd ? '0 : IDX_W'(NR);
  endfunction

  // Last index served in a pass; rk_last marks it.
  function automatic logic [IDX_W-1:0] end_idx(input logic fwd);
    return fwd ? IDX_W'(NR) : '0;
  endfunction

endpackage

// File: rtl/aes_key_sched_buf_if.sv
// Expander-side and consumer-side signals of the round-key buffer.
// fwd exists only when AES_KB_FWD_EN is defined.
interface aes_key_sched_buf_if;
  import aes_kb_pkg::*;

  logic              kld;
  logic              exp_kld_c;
  logic [WORD_W-1:0] wo_0;
  logic [WORD_W-1:0] wo_1;
  logic [WORD_W-1:0] wo_2;
  logic [WORD_W-1:0] wo_3;
  logic              kdone;
  logic [RK_W-1:0]   rk;
  logic [IDX_W-1:0]  rk_idx;
  logic              rk_vld;
  logic              rk_rdy;
  logic              rk_last;
`ifdef AES_KB_FWD_EN
  logic              fwd;

  modport slave (
    input  kld, wo_0, wo_1, wo_2, wo_3, rk_rdy, fwd,
    output exp_kld_c, kdone, rk, rk_idx, rk_vld, rk_last
  );
  modport master (
    output kld, wo_0, wo_1, wo_2, wo_3, rk_rdy, fwd,
    input  exp_kld_c, kdone, rk, rk_idx, rk_vld, rk_last
  );
`else
  modport slave (
    input  kld, wo_0, wo_1, wo_2, wo_3, rk_rdy,
    output exp_kld_c, kdone, rk, rk_idx, rk_vld, rk_last
  );
  modport master (
    output kld, wo_0, wo_1, wo_2, wo_3, rk_rdy,
    input  exp_kld_c, kdone, rk, rk_idx, rk_vld, rk_last
  );
`endif

endinterface

// File: rtl/aes_kb_rf.sv
// (NR+1) x 128 round-key storage: one synchronous write port, one asynchronous read port.
module aes_kb_rf
  import aes_kb_pkg::*;
(
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [RK_W-1:0]  i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [RK_W-1:0]  o_rdata_c
);

  logic [RK_W-1:0] r_mem [NK];

  // Contents are don't-care until captured, so no reset on the array.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/aes_key_sched_buf.sv
// Captures RK0..RK10 from the AES-128 expander and replays them over valid/ready,
// reverse order by default; AES_KB_FWD_EN adds a fwd input selecting forward order.
module aes_key_sched_buf
  import aes_kb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  aes_key_sched_buf_if.slave bus
);

  kb_state_e        r_state;
  logic [IDX_W-1:0] r_wr_ptr;
  logic [IDX_W-1:0] r_rk_idx;
  logic [RK_W-1:0]  r_rk;
  logic             r_kdone;
  logic             r_rk_vld;
  logic             r_rk_last;
  logic             r_fwd;

  logic             w_we;
  logic             w_fwd_in;
  logic             w_fwd_nxt;
  logic [IDX_W-1:0] w_nxt_idx;
  logic [RK_W-1:0]  w_wdata;
  logic [RK_W-1:0]  w_rdata_c;
  logic [RK_W-1:0]  w_rk_nxt;
  rk_words_t        w_words;

  assign w_words = '{w0: bus.wo_0, w1: bus.wo_1, w2: bus.wo_2, w3: bus.wo_3};
  assign w_wdata = RK_W'(w_words);
  assign w_we    = (r_state == CAPT) && !bus.kld;

`ifdef AES_KB_FWD_EN
  assign w_fwd_in = bus.fwd;
`else
  assign w_fwd_in = 1'b0;
`endif

  // Next index to present: restart a pass on SERVE entry or after the last key, else step.
  always_comb begin
    w_fwd_nxt = r_fwd;
    w_nxt_idx = r_rk_idx;
    if ((r_state != SERVE) || (r_rk_idx == end_idx(r_fwd))) begin
      w_fwd_nxt = w_fwd_in;
      w_nxt_idx = start_idx(w_fwd_in);
    end else if (r_fwd) begin
      w_nxt_idx = r_rk_idx + IDX_W'(1);
    end else begin
      w_nxt_idx = r_rk_idx - IDX_W'(1);
    end
  end

  // RK10 is being written on the same edge it is first presented, so bypass the array.
  assign w_rk_nxt = (w_we && (r_wr_ptr == w_nxt_idx)) ? w_wdata : w_rdata_c;

  aes_kb_rf u_rf (
    .clk       (clk),
    .i_we      (w_we),
    .i_waddr   (r_wr_ptr),
    .i_wdata   (w_wdata),
    .i_raddr   (w_nxt_idx),
    .o_rdata_c (w_rdata_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_wr_ptr  <= '0;
      r_rk_idx  <= IDX_W'(NR);
      r_rk      <= '0;
      r_kdone   <= 1'b0;
      r_rk_vld  <= 1'b0;
      r_rk_last <= 1'b0;
      r_fwd     <= 1'b0;
    end else if (bus.kld) begin
      // A new key wins over everything, including a handshake this cycle.
      r_state   <= CAPT;
      r_wr_ptr  <= '0;
      r_kdone   <= 1'b0;
      r_rk_vld  <= 1'b0;
      r_rk_last <= 1'b0;
    end else begin
      case (r_state)
        CAPT: begin
          r_wr_ptr <= r_wr_ptr + IDX_W'(1);
          if (r_wr_ptr == IDX_W'(NR)) begin
            r_state   <= SERVE;
            r_kdone   <= 1'b1;
            r_rk_vld  <= 1'b1;
            r_rk_idx  <= w_nxt_idx;
            r_rk      <= w_rk_nxt;
            r_fwd     <= w_fwd_nxt;
            r_rk_last <= (w_nxt_idx == end_idx(w_fwd_nxt));
          end
        end
        SERVE: begin
          if (bus.rk_rdy) begin
            r_rk_idx  <= w_nxt_idx;
            r_rk      <= w_rk_nxt;
            r_fwd     <= w_fwd_nxt;
            r_rk_last <= (w_nxt_idx == end_idx(w_fwd_nxt));
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.exp_kld_c = bus.kld;
  assign bus.kdone     = r_kdone;
  assign bus.rk        = r_rk;
  assign bus.rk_idx    = r_rk_idx;
  assign bus.rk_vld    = r_rk_vld;
  assign bus.rk_last   = r_rk_last;

endmodule

// File: tb/tb_aes_key_sched_buf.sv
// Scoreboard bench for aes_key_sched_buf with a behavioural AES-128 key expander.
module tb_aes_key_sched_buf;
  import aes_kb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  aes_key_sched_buf_if bus();

  aes_key_sched_buf dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [127:0] rk;
    logic [3:0]   idx;
    logic         last;
  } exp_t;

  exp_t         q[$];
  exp_t         m_e;
  int           checks = 0;
  int           errors = 0;
  logic [7:0]   sb [256];
  logic [127:0] m_rks [11];
  logic [4:0]   m_cnt = '0;
  logic [127:0] m_wo;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_RK1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] FIPS_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from first principles: GF(2^8) inverse (a^254) then the affine map.
  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) m_rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Expander model: key latched on kld, then one round key per cycle.
  always @(posedge clk) begin
    if (bus.exp_kld_c) m_cnt <= 5'd0;
    else if (m_cnt != 5'd31) m_cnt <= m_cnt + 5'd1;
  end

  always_comb begin
    m_wo = {4{32'hdead_beef}};
    if (m_cnt <= 5'd10) m_wo = m_rks[m_cnt[3:0]];
  end

  assign bus.wo_0 = m_wo[127:96];
  assign bus.wo_1 = m_wo[95:64];
  assign bus.wo_2 = m_wo[63:32];
  assign bus.wo_3 = m_wo[31:0];

  task automatic push_pass(input int n, input bit f);
    for (int k = 0; k < n; k++) begin
      int idx;
      exp_t e;
      idx    = f ? (k % 11) : (10 - k % 11);
      e.rk   = m_rks[idx];
      e.idx  = 4'(idx);
      e.last = f ? (idx == 10) : (idx == 0);
      q.push_back(e);
    end
  endtask

  // Monitor: compare every accepted key; check stability across stalled cycles.
  logic         p_hold = 1'b0;
  logic [127:0] p_rk;
  logic [3:0]   p_idx;
  always @(negedge clk) begin
    if (rst && p_hold) begin
      chk("hold_vld", 128'(bus.rk_vld), 128'(1));
      chk("hold_rk", bus.rk, p_rk);
      chk("hold_idx", 128'(bus.rk_idx), 128'(p_idx));
    end
    p_hold = rst && !bus.kld && bus.rk_vld && !bus.rk_rdy;
    p_rk   = bus.rk;
    p_idx  = bus.rk_idx;
    if (rst && !bus.kld && bus.rk_vld && bus.rk_rdy) begin
      if (q.size() == 0) begin
        chk("unexpected_hs_idx", 128'(bus.rk_idx), 128'hffff);
      end else begin
        m_e = q.pop_front();
        chk("hs_rk", bus.rk, m_e.rk);
        chk("hs_idx", 128'(bus.rk_idx), 128'(m_e.idx));
        chk("hs_last", 128'(bus.rk_last), 128'(m_e.last));
        chk("hs_kdone", 128'(bus.kdone), 128'(1));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] key, input int hold, input int npush, input bit f);
    int n;
    chk("queue_empty_at_load", 128'(q.size()), 128'(0));
    expand(key);
    bus.kld    = 1'b1;
    bus.rk_rdy = 1'b1;
    for (int i = 0; i < hold; i++) begin
      step();
      if (i == 0) begin
        chk("kld_clr_vld", 128'(bus.rk_vld), 128'(0));
        chk("kld_clr_kdone", 128'(bus.kdone), 128'(0));
        chk("exp_kld_fwd", 128'(bus.exp_kld_c), 128'(1));
      end
    end
    bus.kld = 1'b0;
    q.delete();
    push_pass(npush, f);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.rk_vld && n < 30);
    chk("latency", 128'(n), 128'(11));
    chk("kdone_up", 128'(bus.kdone), 128'(1));
  endtask

  task automatic drain(input bit rnd, input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      bus.rk_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      n++;
    end
    bus.rk_rdy = 1'b0;
    chk("drain_done", 128'(q.size()), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic ok;
    bus.kld    = 1'b0;
    bus.rk_rdy = 1'b0;
`ifdef AES_KB_FWD_EN
    bus.fwd    = 1'b0;
`endif
    for (int i = 0; i < 256; i++) sb[i] = sbox_f(8'(i));
    expand(128'h0);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_kdone", 128'(bus.kdone), 128'(0));
    chk("rst_vld", 128'(bus.rk_vld), 128'(0));
    chk("rst_idx", 128'(bus.rk_idx), 128'(10));
    chk("rst_rk", bus.rk, 128'h0);
    rst = 1'b1;
    step();

    // FIPS-197 key, rk_rdy held high
    load_key(FIPS_KEY, 1, 22, 1'b0);
    chk("fips_first_idx", 128'(bus.rk_idx), 128'(10));
    chk("fips_rk10", bus.rk, FIPS_RK10);
    for (int i = 0; i < 20 && bus.rk_idx != 4'd1; i++) step();
    chk("fips_rk1", bus.rk, FIPS_RK1);
    step();
    chk("fips_idx0", 128'(bus.rk_idx), 128'(0));
    chk("fips_rk0", bus.rk, FIPS_KEY);
    chk("fips_last", 128'(bus.rk_last), 128'(1));
    step();
    chk("fips_wrap_idx", 128'(bus.rk_idx), 128'(10));
    chk("fips_wrap_vld", 128'(bus.rk_vld), 128'(1));
    drain(1'b0, 200);

    // Backpressure: three full passes with random rk_rdy
    push_pass(33, 1'b0);
    drain(1'b1, 2000);

    // New key while idx 6 is presented and rk_rdy is high
    push_pass(4, 1'b0);
    drain(1'b0, 100);
    chk("mid_serve_idx", 128'(bus.rk_idx), 128'(6));
    load_key({$urandom, $urandom, $urandom, $urandom}, 1, 11, 1'b0);
    drain(1'b1, 1000);

    // Asynchronous reset during capture
    expand({$urandom, $urandom, $urandom, $urandom});
    bus.kld    = 1'b1;
    bus.rk_rdy = 1'b1;
    step();
    bus.kld = 1'b0;
    repeat (5) step();
    #2 rst = 1'b0;
    #1;
    chk("arst_kdone", 128'(bus.kdone), 128'(0));
    chk("arst_vld", 128'(bus.rk_vld), 128'(0));
    chk("arst_idx", 128'(bus.rk_idx), 128'(10));
    chk("arst_rk", bus.rk, 128'h0);
    repeat (2) step();
    rst = 1'b1;
    ok  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.rk_vld || bus.kdone) ok = 1'b0;
    end
    chk("arst_no_vld", 128'(ok), 128'(1));

    // kld held for three cycles
    load_key({$urandom, $urandom, $urandom, $urandom}, 3, 22, 1'b0);
    drain(1'b1, 2000);

`ifdef AES_KB_FWD_EN
    // Forward order
    bus.fwd = 1'b1;
    load_key({$urandom, $urandom, $urandom, $urandom}, 1, 22, 1'b1);
    chk("fwd_first_idx", 128'(bus.rk_idx), 128'(0));
    drain(1'b1, 2000);
    bus.fwd = 1'b0;
`endif

    repeat (3) step();
    chk("final_queue_empty", 128'(q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
